// File: rtl/trg_mon_readout.sv
// ---------------------------------------------------------------------------
// trg_mon_readout
//
// Monitor readout for the trigger board. A snapshot copies every live 16-bit
// register and 32-bit counter into shadow registers in one edge. The shadow
// words are then served to the housekeeping link as single reads or as
// streamed bursts with valid/ready back-pressure.
//
// Word address map (TOTAL = NUM_REG + 2*NUM_CNT32):
//   a < NUM_REG          : shadow register a
//   NUM_REG <= a < TOTAL : counter (a-NUM_REG)>>1, even = low half, odd = high
//   a >= TOTAL           : ERR_WORD, and addr_err_out is set
//
// Ports:
//   clk_in, rst_in         clock, asynchronous active-high reset
//   reg_bus_in             live registers, register i at [16i+15:16i]
//   cnt_bus_in             live counters, counter k at [32k+31:32k]
//   snap_in                snapshot request pulse
//   snap_done_out          one-cycle pulse, shadows were just updated
//   rd_in                  single-read request pulse
//   burst_in               burst-start pulse
//   rd_addr_in             start address, sampled with rd_in / burst_in
//   burst_len_in           burst word count, sampled with burst_in
//   abort_in               ends an active read or burst
//   data_out               read data
//   data_valid_out         data_out holds a word
//   data_ready_in          consumer takes the word
//   data_last_out          final word of a burst or single read
//   busy_out               not idle
//   addr_err_out           sticky out-of-range flag, cleared by snap_in
//   state_dbg_out          current FSM state, for observation only
//
// Handshake: a word transfers on a rising edge where data_valid_out and
// data_ready_in are both high. While data_valid_out is high and
// data_ready_in is low, data_out and data_last_out stay constant. abort_in
// wins over a same-cycle handshake: that word is not transferred.
// ---------------------------------------------------------------------------
module trg_mon_readout #(
    parameter int          NUM_REG   = 32,
    parameter int          NUM_CNT32 = 2,
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] ERR_WORD  = 16'hDEAD
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic [16*NUM_REG-1:0]                         reg_bus_in,
    input  logic [(NUM_CNT32 > 0 ? 32*NUM_CNT32 : 1)-1:0] cnt_bus_in,
    input  logic                                          snap_in,
    output logic                                          snap_done_out,
    input  logic                                          rd_in,
    input  logic                                          burst_in,
    input  logic [ADDR_W-1:0]                             rd_addr_in,
    input  logic [ADDR_W-1:0]                             burst_len_in,
    input  logic                                          abort_in,
    output logic [15:0]                                   data_out,
    output logic                                          data_valid_out,
    input  logic                                          data_ready_in,
    output logic                                          data_last_out,
    output logic                                          busy_out,
    output logic                                          addr_err_out,
    output logic [1:0]                                    state_dbg_out
);

    localparam int TOTAL = NUM_REG + 2*NUM_CNT32;
    localparam int SH_W  = 16*TOTAL;
    // One extra address bit so a burst running past the top of the address
    // space keeps returning ERR_WORD instead of wrapping back to word 0.
    localparam int AX_W  = ADDR_W + 1;
    localparam logic [AX_W-1:0] TOTAL_A = AX_W'(TOTAL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_BURST  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AX_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [15:0]       data_q, data_d;
    logic              last_q, last_d;
    logic              snap_pend_q, snap_pend_d;
    logic              snap_done_q;
    logic              err_q, err_d;
    logic [SH_W-1:0]   shadow_q;

    logic [SH_W-1:0]   live_words;
    logic              do_snap;
    logic              load;
    logic [AX_W-1:0]   load_addr;
    logic              load_oob;
    logic [15:0]       load_word;

    // Counter k low half lands on word NUM_REG+2k and high half on
    // NUM_REG+2k+1, so a plain concatenation gives the whole word map.
    generate
        if (NUM_CNT32 > 0) begin : g_cnt
            assign live_words = {cnt_bus_in, reg_bus_in};
        end else begin : g_nocnt
            logic unused_cnt;
            assign unused_cnt = ^cnt_bus_in;
            assign live_words = reg_bus_in;
        end
    endgenerate

    // Captures only in IDLE, so shadows never change under an active read.
    assign do_snap = (state_q == ST_IDLE) && (snap_in || snap_pend_q);

    always_comb begin
        load_oob  = (load_addr >= TOTAL_A);
        load_word = ERR_WORD;
        if (!load_oob) begin
            load_word = shadow_q[{load_addr, 4'b0000} +: 16];
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        data_d    = data_q;
        last_d    = last_q;
        load      = 1'b0;
        load_addr = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (burst_in) begin
                    // A zero-length burst is dropped, and it still takes
                    // precedence over a simultaneous rd_in.
                    if (burst_len_in != '0) begin
                        state_d   = ST_BURST;
                        addr_d    = {1'b0, rd_addr_in};
                        rem_d     = burst_len_in;
                        load      = 1'b1;
                        load_addr = {1'b0, rd_addr_in};
                        last_d    = (burst_len_in == ADDR_W'(1));
                    end
                end else if (rd_in) begin
                    state_d   = ST_SINGLE;
                    load      = 1'b1;
                    load_addr = {1'b0, rd_addr_in};
                    last_d    = 1'b1;
                end
            end
            ST_SINGLE: begin
                if (abort_in || data_ready_in) begin
                    state_d = ST_IDLE;
                    data_d  = 16'h0000;
                    last_d  = 1'b0;
                end
            end
            ST_BURST: begin
                if (abort_in || (data_ready_in && rem_q == ADDR_W'(1))) begin
                    state_d = ST_IDLE;
                    data_d  = 16'h0000;
                    last_d  = 1'b0;
                end else if (data_ready_in) begin
                    addr_d    = addr_q + AX_W'(1);
                    rem_d     = rem_q - ADDR_W'(1);
                    load      = 1'b1;
                    load_addr = addr_q + AX_W'(1);
                    last_d    = (rem_q == ADDR_W'(2));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            data_d = load_word;
        end
    end

    always_comb begin
        snap_pend_d = 1'b0;
        if (state_q != ST_IDLE) begin
            snap_pend_d = snap_pend_q || snap_in;
        end
        // Setting wins so an out-of-range word is never lost to a
        // same-cycle snapshot request.
        err_d = err_q;
        if (load && load_oob) begin
            err_d = 1'b1;
        end else if (snap_in) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            data_q      <= 16'h0000;
            last_q      <= 1'b0;
            snap_pend_q <= 1'b0;
            snap_done_q <= 1'b0;
            err_q       <= 1'b0;
            shadow_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            last_q      <= last_d;
            snap_pend_q <= snap_pend_d;
            snap_done_q <= do_snap;
            err_q       <= err_d;
            if (do_snap) begin
                shadow_q <= live_words;
            end
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = (state_q != ST_IDLE);
    assign data_last_out  = last_q;
    assign busy_out       = (state_q != ST_IDLE);
    assign snap_done_out  = snap_done_q;
    assign addr_err_out   = err_q;
    assign state_dbg_out  = state_q;

endmodule
